// File: rtl/arm_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arm_cond_pkg
//  Description : Shared types and constants for the ARM conditional-execution
//                stage: condition-code encoding and NZCV flag bit positions.
//  Revision    : 1.0  initial release
// ============================================================================
package arm_cond_pkg;

  // Instr[31:28] condition field encodings
  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// ============================================================================
//  Module      : cond_check
//  Description : Pure combinational condition evaluator. Decides whether an
//                instruction executes from its condition field and the
//                architectural NZCV flags.
//  Revision    : 1.0  initial release
// ============================================================================
module cond_check
  import arm_cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_n = Flags[FLAG_N];
  assign w_z = Flags[FLAG_Z];
  assign w_c = Flags[FLAG_C];
  assign w_v = Flags[FLAG_V];

  // Condition-code decode; NV (1111) never executes
  always_comb begin
    CondEx = 1'b0;
    case (cond_e'(Cond))
      EQ: CondEx = w_z;
      NE: CondEx = ~w_z;
      CS: CondEx = w_c;
      CC: CondEx = ~w_c;
      MI: CondEx = w_n;
      PL: CondEx = ~w_n;
      VS: CondEx = w_v;
      VC: CondEx = ~w_v;
      HI: CondEx = w_c & ~w_z;
      LS: CondEx = ~w_c | w_z;
      GE: CondEx = (w_n == w_v);
      LT: CondEx = (w_n != w_v);
      GT: CondEx = ~w_z & (w_n == w_v);
      LE: CondEx = w_z | (w_n != w_v);
      AL: CondEx = 1'b1;
      NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cond_unit
//  Description : Conditional-execution stage. Evaluates the condition field
//                against the registered NZCV flags, gates PC/register/memory
//                write strobes, supplies the ALU carry-in for RSC, owns the
//                flag register and counts retired/squashed instructions.
//  Revision    : 1.0  initial release
// ============================================================================
module cond_unit
  import arm_cond_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StepEn,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             RSCSignal,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic             CarryIn,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] RetiredCount,
  output logic [CNT_W-1:0] SquashedCount
);

  logic [3:0]       flags_q;
  logic [3:0]       flags_d;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] retired_d;
  logic [CNT_W-1:0] squashed_q;
  logic [CNT_W-1:0] squashed_d;
  logic             w_cond_ex;

  // Condition is judged only against the registered flags, so a
  // flag-setting instruction never influences its own execution.
  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (flags_q),
    .CondEx (w_cond_ex)
  );

  // Gated strobes and RSC carry-in; reset is deliberately not folded in here
  always_comb begin
    CondEx   = w_cond_ex;
    PCSrc    = PCS  & w_cond_ex & StepEn;
    RegWrite = RegW & w_cond_ex & StepEn;
    MemWrite = MemW & w_cond_ex & StepEn;
    CarryIn  = RSCSignal ? flags_q[FLAG_C] : 1'b0;
  end

  // Next-state: per-group flag writes and one outcome counter per completed instr
  always_comb begin
    flags_d    = flags_q;
    retired_d  = retired_q;
    squashed_d = squashed_q;
    if (StepEn) begin
      if (w_cond_ex) begin
        if (FlagW[1]) begin
          flags_d[FLAG_N] = ALUFlags[FLAG_N];
          flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
        end
        if (FlagW[0]) begin
          flags_d[FLAG_C] = ALUFlags[FLAG_C];
          flags_d[FLAG_V] = ALUFlags[FLAG_V];
        end
        retired_d = retired_q + CNT_W'(1);
      end else begin
        squashed_d = squashed_q + CNT_W'(1);
      end
    end
  end

  // State registers; synchronous reset dominates StepEn
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q    <= 4'b0000;
      retired_q  <= '0;
      squashed_q <= '0;
    end else begin
      flags_q    <= flags_d;
      retired_q  <= retired_d;
      squashed_q <= squashed_d;
    end
  end

  assign Flags         = flags_q;
  assign RetiredCount  = retired_q;
  assign SquashedCount = squashed_q;

endmodule
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cond_unit
//  Description : Self-checking bench for cond_unit. A reference model predicts
//                every output for each driven instruction; expectations are
//                queued at drive time and popped when the outputs are sampled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cond_unit;

  localparam int CNT_W = 32;

  logic             clk;
  logic             reset;
  logic             StepEn;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             RSCSignal;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic             CarryIn;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] RetiredCount;
  logic [CNT_W-1:0] SquashedCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string            tag;
    logic             pcsrc;
    logic             regwrite;
    logic             memwrite;
    logic             condex;
    logic             carryin;
    logic [3:0]       flags;
    logic [CNT_W-1:0] retired;
    logic [CNT_W-1:0] squashed;
  } exp_t;

  exp_t sb[$];

  // Reference state
  logic [3:0]       m_flags;
  logic [CNT_W-1:0] m_ret;
  logic [CNT_W-1:0] m_sq;

  cond_unit #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .StepEn        (StepEn),
    .Cond          (Cond),
    .ALUFlags      (ALUFlags),
    .FlagW         (FlagW),
    .PCS           (PCS),
    .RegW          (RegW),
    .MemW          (MemW),
    .RSCSignal     (RSCSignal),
    .PCSrc         (PCSrc),
    .RegWrite      (RegWrite),
    .MemWrite      (MemWrite),
    .CondEx        (CondEx),
    .CarryIn       (CarryIn),
    .Flags         (Flags),
    .RetiredCount  (RetiredCount),
    .SquashedCount (SquashedCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one instruction at the falling edge, queue the prediction, sample
  // shortly after, then advance the model across the following rising edge.
  task automatic step(input string tag, input logic [3:0] c, input logic [3:0] af,
                      input logic [1:0] fw, input logic pcs, input logic regw,
                      input logic memw, input logic rsc, input logic se, input logic rst);
    exp_t e;
    exp_t g;
    @(negedge clk);
    Cond = c; ALUFlags = af; FlagW = fw; PCS = pcs; RegW = regw;
    MemW = memw; RSCSignal = rsc; StepEn = se; reset = rst;
    e.tag      = tag;
    e.condex   = cond_model(c, m_flags);
    e.pcsrc    = pcs  & e.condex & se;
    e.regwrite = regw & e.condex & se;
    e.memwrite = memw & e.condex & se;
    e.carryin  = rsc ? m_flags[1] : 1'b0;
    e.flags    = m_flags;
    e.retired  = m_ret;
    e.squashed = m_sq;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    chk({g.tag, ".condex"},   CONDEXT(CondEx),   CONDEXT(g.condex));
    chk({g.tag, ".pcsrc"},    CONDEXT(PCSrc),    CONDEXT(g.pcsrc));
    chk({g.tag, ".regwrite"}, CONDEXT(RegWrite), CONDEXT(g.regwrite));
    chk({g.tag, ".memwrite"}, CONDEXT(MemWrite), CONDEXT(g.memwrite));
    chk({g.tag, ".carryin"},  CONDEXT(CarryIn),  CONDEXT(g.carryin));
    chk({g.tag, ".flags"},    CNT_W'(Flags),     CNT_W'(g.flags));
    chk({g.tag, ".retired"},  RetiredCount,      g.retired);
    chk({g.tag, ".squashed"}, SquashedCount,     g.squashed);
    if (rst) begin
      m_flags = 4'b0000;
      m_ret   = '0;
      m_sq    = '0;
    end else if (se) begin
      if (e.condex) begin
        if (fw[1]) m_flags[3:2] = af[3:2];
        if (fw[0]) m_flags[1:0] = af[1:0];
        m_ret = m_ret + 1'b1;
      end else begin
        m_sq = m_sq + 1'b1;
      end
    end
  endtask

  function automatic logic [CNT_W-1:0] CONDEXT(input logic b);
    return {{(CNT_W-1){1'b0}}, b};
  endfunction

  initial begin
    reset = 1'b1; StepEn = 1'b0; Cond = 4'he; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; RSCSignal = 1'b0;
    m_flags = 4'b0000; m_ret = '0; m_sq = '0;
    repeat (2) @(posedge clk);

    // Post-reset condition behaviour and counters
    step("rst_eq", 4'b0000, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_eq_regwrite_zero", CONDEXT(RegWrite), CONDEXT(1'b0));
    step("rst_ne", 4'b0001, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ne_regwrite_one", CONDEXT(RegWrite), CONDEXT(1'b1));
    chk("eq_squashed_one", SquashedCount, 32'd1);
    step("after_ne", 4'b1111, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ne_retired_one", RetiredCount, 32'd1);

    // CMP then BEQ / BNE back to back
    step("cmp", 4'b1110, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("beq", 4'b0000, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("beq_flags", CNT_W'(Flags), 32'h6);
    chk("beq_pcsrc", CONDEXT(PCSrc), CONDEXT(1'b1));
    step("bne", 4'b0001, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bne_pcsrc", CONDEXT(PCSrc), CONDEXT(1'b0));

    // Independent N,Z group write from cleared flags
    step("rst2", 4'b1110, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("nz_only", 4'b1110, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("ge", 4'b1010, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("nz_only_flags", CNT_W'(Flags), 32'hC);
    chk("ge_condex", CONDEXT(CondEx), CONDEXT(1'b0));
    step("lt", 4'b1011, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("lt_condex", CONDEXT(CondEx), CONDEXT(1'b1));

    // RSC carry-in from registered C
    step("set_c1", 4'b1110, 4'b0010, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("rsc_c1", 4'b1110, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rsc_c1_carry", CONDEXT(CarryIn), CONDEXT(1'b1));
    step("set_c0", 4'b1110, 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("rsc_c0", 4'b1110, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rsc_c0_carry", CONDEXT(CarryIn), CONDEXT(1'b0));
    step("set_c1b", 4'b1110, 4'b0010, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("norsc_c1", 4'b1110, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("norsc_c1_carry", CONDEXT(CarryIn), CONDEXT(1'b0));

    // Stall: no strobes, no state change
    step("stall", 4'b1110, 4'b0101, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stall_memwrite", CONDEXT(MemWrite), CONDEXT(1'b0));
    step("after_stall", 4'b1111, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random instruction mix across all condition codes
    for (int i = 0; i < 60; i++) begin
      step($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), 1'b0);
    end

    // Retired counter wrap
    force dut.retired_q = {CNT_W{1'b1}};
    #1;
    release dut.retired_q;
    m_ret = {CNT_W{1'b1}};
    step("wrap_pre", 4'b1110, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("wrap_post", 4'b1111, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("wrap_zero", RetiredCount, 32'h0);

    // Reset mid-stream with a flag-setting instruction
    step("mid_rst", 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step("after_mid_rst", 4'b1111, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_flags", CNT_W'(Flags), 32'h0);
    chk("mid_rst_retired", RetiredCount, 32'h0);
    chk("mid_rst_squashed", SquashedCount, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
